// File: rtl/pwm_core_pkg.sv
// Shared definitions for the SecondIP_PWM peripheral: FSM states,
// control-register bit positions and register map offsets.
package pwm_core_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_e;

  // Control register (offset 0x0) bit positions
  localparam int unsigned EN_BIT  = 0;
  localparam int unsigned POL_BIT = 1;

  // Register byte offsets, shared with the AXI4-Lite slave
  localparam logic [3:0] REG_CTRL_OFS     = 4'h0;
  localparam logic [3:0] REG_PERIOD_OFS   = 4'h4;
  localparam logic [3:0] REG_DUTY_OFS     = 4'h8;
  localparam logic [3:0] REG_PRESCALE_OFS = 4'hC;

endpackage

// File: rtl/pwm_prescaler.sv
// Prescaler: produces a one-cycle tick every pre_val+1 clocks; clr holds it at zero.
module pwm_prescaler #(
  parameter int unsigned PRE_W = 16
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             clr,
  input  logic [PRE_W-1:0] pre_val,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;

  assign tick = (pre_cnt_q == pre_val);

  // Next prescale count: cleared, wrapped on tick, or incremented
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clr || tick) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + PRE_W'(1);
    end
  end

  // Prescale count register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/pwm_core.sv
// PWM engine: shadow-buffered period/duty/prescale/polarity, period counter,
// IDLE/RUN control FSM and registered PWM output with per-period strobe.
module pwm_core
  import pwm_core_pkg::*;
#(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PRE_W = 16
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             ctrl_enable,
  input  logic             ctrl_polarity,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic [PRE_W-1:0] prescale,
  output logic             pwm_out,
  output logic             period_done,
  output logic             running,
  output logic [CNT_W-1:0] count
);

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_sh_q, period_sh_d;
  logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
  logic [PRE_W-1:0] pre_sh_q, pre_sh_d;
  logic             pol_sh_q, pol_sh_d;
  logic             pwm_q, pwm_d;
  logic             done_q, done_d;
  logic [1:0]       ctrl;
  logic             tick;
  logic             pre_clr;

  assign ctrl[EN_BIT]  = ctrl_enable;
  assign ctrl[POL_BIT] = ctrl_polarity;

  // Prescaler only runs while RUN persists; it is zeroed the same edge RUN is left
  // so a re-enable always starts a full first tick.
  assign pre_clr = (state_q != RUN) || !ctrl[EN_BIT];

  pwm_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .clr     (pre_clr),
    .pre_val (pre_sh_q),
    .tick    (tick)
  );

  // FSM, period counter, shadow reload and output next-state logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    pre_sh_d    = pre_sh_q;
    pol_sh_d    = pol_sh_q;
    pwm_d       = pwm_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        pwm_d = ctrl[POL_BIT];
        if (ctrl[EN_BIT]) begin
          period_sh_d = period;
          duty_sh_d   = duty;
          pre_sh_d    = prescale;
          pol_sh_d    = ctrl[POL_BIT];
          state_d     = RUN;
        end
      end
      RUN: begin
        if (!ctrl[EN_BIT]) begin
          state_d = IDLE;
          cnt_d   = '0;
          pwm_d   = ctrl[POL_BIT];
        end else begin
          pwm_d = (cnt_q < duty_sh_q) ^ pol_sh_q;
          if (tick) begin
            if (cnt_q == period_sh_q) begin
              cnt_d       = '0;
              period_sh_d = period;
              duty_sh_d   = duty;
              pre_sh_d    = prescale;
              pol_sh_d    = ctrl[POL_BIT];
              done_d      = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, shadow and output registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      period_sh_q <= '0;
      duty_sh_q   <= '0;
      pre_sh_q    <= '0;
      pol_sh_q    <= 1'b0;
      pwm_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      period_sh_q <= period_sh_d;
      duty_sh_q   <= duty_sh_d;
      pre_sh_q    <= pre_sh_d;
      pol_sh_q    <= pol_sh_d;
      pwm_q       <= pwm_d;
      done_q      <= done_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_done = done_q;
  assign running     = (state_q == RUN);
  assign count       = cnt_q;

endmodule
